// File: rtl/sram_access_sequencer.sv
// rtl/sram_access_sequencer.sv - multi-cycle EN/OE/WE strobe sequencer for RAM1 async SRAM
module sram_access_sequencer #(
    parameter int unsigned RD_WAIT  = 1,
    parameter int unsigned WR_WIDTH = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [15:0] address,
    input  logic [15:0] dataIn,
    output logic [15:0] dataOut,
    output logic        memStall,
    output logic        memDone,
    output logic        ram1EN,
    output logic        ram1OE,
    output logic        ram1WE,
    output logic [15:0] ram1Addr,
    inout  wire  [15:0] ram1Data
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_STROBE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [2:0] RD_CNT = 3'(RD_WAIT);
    localparam logic [2:0] WR_CNT = 3'(WR_WIDTH - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        en_q, en_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    logic        drv_q, drv_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // write wins over a simultaneous read; the read is simply dropped
                if (memWrite) begin
                    addr_d  = address;
                    wdata_d = dataIn;
                    state_d = WR_SETUP;
                end else if (memRead) begin
                    addr_d  = address;
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                cnt_d   = RD_CNT;
                state_d = RD_STROBE;
            end
            RD_STROBE: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = ram1Data;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_SETUP: begin
                cnt_d   = WR_CNT;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == 3'd0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // strobes are decoded from the next state so the pins come straight off flops
        en_d   = (state_d == IDLE) || (state_d == DONE);
        oe_d   = (state_d != RD_STROBE);
        we_d   = (state_d != WR_PULSE);
        drv_d  = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
            en_q    <= 1'b1;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            drv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            drv_q   <= drv_d;
            done_q  <= done_d;
        end
    end

    assign memStall = ((state_q == IDLE) && (memRead || memWrite))
                    || ((state_q != IDLE) && (state_q != DONE));
    assign memDone  = done_q;
    assign dataOut  = rdata_q;
    assign ram1EN   = en_q;
    assign ram1OE   = oe_q;
    assign ram1WE   = we_q;
    assign ram1Addr = addr_q;
    assign ram1Data = drv_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// tb/tb_sram_access_sequencer.sv - directed bench for sram_access_sequencer with RAM1 model
module tb_sram_access_sequencer;

    logic        CLK;
    logic        RST;
    logic        memRead;
    logic        memWrite;
    logic [15:0] address;
    logic [15:0] dataIn;
    logic [15:0] dataOut;
    logic        memStall;
    logic        memDone;
    logic        ram1EN;
    logic        ram1OE;
    logic        ram1WE;
    logic [15:0] ram1Addr;
    wire  [15:0] ram1Data;

    logic [15:0] sram [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] en_lo, oe_lo, we_lo, done_m, stall_m, bus_ok, addr_ok;

    int  cyc         = 0;
    int  last_we_low = -100;
    int  oe_fall_gap = 0;
    int  oe_we_both  = 0;
    logic prev_oe    = 1'b1;

    sram_access_sequencer #(
        .RD_WAIT (1),
        .WR_WIDTH(2)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .memRead (memRead),
        .memWrite(memWrite),
        .address (address),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .memStall(memStall),
        .memDone (memDone),
        .ram1EN  (ram1EN),
        .ram1OE  (ram1OE),
        .ram1WE  (ram1WE),
        .ram1Addr(ram1Addr),
        .ram1Data(ram1Data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign ram1Data = (!ram1EN && !ram1OE && ram1WE) ? sram[ram1Addr] : 16'hzzzz;

    initial begin
        sram[16'h0040] = 16'hBEEF;
        forever begin
            @(posedge ram1WE);
            if (!ram1EN) sram[ram1Addr] = ram1Data;
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (!ram1WE) last_we_low = cyc;
        if (!ram1OE && prev_oe) oe_fall_gap = cyc - last_we_low;
        if (!ram1OE && !ram1WE) oe_we_both = oe_we_both + 1;
        prev_oe = ram1OE;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input int n);
        en_lo = '0; oe_lo = '0; we_lo = '0; done_m = '0;
        stall_m = '0; bus_ok = '0; addr_ok = '0;
        @(posedge CLK); #1;
        memRead = rd; memWrite = wr; address = a; dataIn = d;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge CLK); #1;
                if (i == 1) begin
                    memRead = 1'b0; memWrite = 1'b0; address = ~a; dataIn = ~d;
                end
            end
            @(negedge CLK);
            en_lo[i]   = !ram1EN;
            oe_lo[i]   = !ram1OE;
            we_lo[i]   = !ram1WE;
            done_m[i]  = memDone;
            stall_m[i] = memStall;
            bus_ok[i]  = (ram1Data === d);
            addr_ok[i] = (ram1Addr === a);
        end
    endtask

    initial begin
        RST = 1'b1; memRead = 1'b0; memWrite = 1'b0; address = '0; dataIn = '0;
        #3;
        check("rst_en",    32'(ram1EN),   32'd1);
        check("rst_oe",    32'(ram1OE),   32'd1);
        check("rst_we",    32'(ram1WE),   32'd1);
        check("rst_done",  32'(memDone),  32'd0);
        check("rst_stall", 32'(memStall), 32'd0);
        check("rst_dout",  32'(dataOut),  32'd0);
        check("rst_addr",  32'(ram1Addr), 32'd0);
        @(posedge CLK); #1; RST = 1'b0;

        run(1'b1, 1'b0, 16'h0040, 16'h0000, 6);
        check("rd_oe",    32'(oe_lo),   32'h000C);
        check("rd_we",    32'(we_lo),   32'h0000);
        check("rd_en",    32'(en_lo),   32'h000E);
        check("rd_done",  32'(done_m),  32'h0010);
        check("rd_stall", 32'(stall_m), 32'h000F);
        check("rd_addr",  32'(addr_ok & 16'h001E), 32'h001E);
        check("rd_dout",  32'(dataOut), 32'hBEEF);

        run(1'b0, 1'b1, 16'h1234, 16'h5A5A, 7);
        check("wr_we",    32'(we_lo),   32'h000C);
        check("wr_oe",    32'(oe_lo),   32'h0000);
        check("wr_en",    32'(en_lo),   32'h001E);
        check("wr_done",  32'(done_m),  32'h0020);
        check("wr_stall", 32'(stall_m), 32'h001F);
        check("wr_bus",   32'(bus_ok & 16'h001E),  32'h001E);
        check("wr_addr",  32'(addr_ok & 16'h001E), 32'h001E);
        check("wr_sram",  32'(sram[16'h1234]), 32'h5A5A);
        check("wr_dout",  32'(dataOut), 32'hBEEF);

        run(1'b1, 1'b1, 16'h0010, 16'h1111, 7);
        check("both_we",   32'(we_lo),  32'h000C);
        check("both_oe",   32'(oe_lo),  32'h0000);
        check("both_done", 32'(done_m), 32'h0020);
        check("both_sram", 32'(sram[16'h0010]), 32'h1111);

        run(1'b0, 1'b1, 16'h0002, 16'hAAAA, 6);
        check("b2b_wdone", 32'(done_m), 32'h0020);
        run(1'b1, 1'b0, 16'h0002, 16'h0000, 6);
        check("b2b_oe",    32'(oe_lo),  32'h000C);
        check("b2b_rdone", 32'(done_m), 32'h0010);
        check("b2b_dout",  32'(dataOut), 32'hAAAA);
        check("b2b_gap",   32'(oe_fall_gap >= 4), 32'd1);
        check("oe_we_excl", 32'(oe_we_both), 32'd0);

        @(posedge CLK); #1; memRead = 1'b1; address = 16'h0040;
        @(posedge CLK); #1; memRead = 1'b0;
        @(posedge CLK); #1;
        check("mid_oe", 32'(ram1OE), 32'd0);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_en",   32'(ram1EN),  32'd1);
        check("mid_rst_oe",   32'(ram1OE),  32'd1);
        check("mid_rst_we",   32'(ram1WE),  32'd1);
        check("mid_rst_dout", 32'(dataOut), 32'd0);
        @(posedge CLK); #1; RST = 1'b0;
        @(negedge CLK);
        check("post_rst_stall", 32'(memStall), 32'd0);
        check("post_rst_addr",  32'(ram1Addr), 32'd0);

        run(1'b1, 1'b0, 16'h0040, 16'h0000, 6);
        check("post_rst_oe",   32'(oe_lo),   32'h000C);
        check("post_rst_dout", 32'(dataOut), 32'hBEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_access_sequencer.md
# sram_access_sequencer

Multi-cycle access sequencer between the MEM stage of the pipelined CPU and the external RAM1 asynchronous SRAM. It turns a single-cycle memRead/memWrite request into a correctly timed EN/OE/WE strobe sequence on the RAM1 pins. It raises memStall to freeze the pipeline for the length of the access. It returns read data together with a one-cycle memDone pulse.

## Interface
- RD_WAIT, 1, extra cycles ram1OE is held low before read data is sampled (0..7)
- WR_WIDTH, 1, cycles ram1WE is held low during a write (1..7)

- CLK  in  1  system clock, all flops rise-edge
- RST  in  1  reset; asynchronous, active-high
- memRead  in  1  read request from MEM stage; sampled only in IDLE
- memWrite  in  1  write request from MEM stage; sampled only in IDLE
- address  in  16  word address, latched at request acceptance
- dataIn  in  16  write data, latched at request acceptance
- dataOut  out  16  last read word; registered
- memStall  out  1  pipeline freeze; high while an access is pending or in progress
- memDone  out  1  one-cycle pulse in DONE state
- ram1EN  out  1  SRAM chip enable, active-low
- ram1OE  out  1  SRAM output enable, active-low
- ram1WE  out  1  SRAM write enable, active-low
- ram1Addr  out  16  SRAM address, from latched address
- ram1Data  inout  16  SRAM data bus; driven only during write states, else Z

## Operation
- States: IDLE, RD_ADDR, RD_STROBE, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A down-counter of 3 bits times RD_STROBE and WR_PULSE.
- IDLE: EN=OE=WE=1, bus Z.
  - memWrite=1: latch address/dataIn, go to WR_SETUP. Write has priority if both requests are high; the read is dropped.
  - Else memRead=1: latch address, go to RD_ADDR.
  - Else stay in IDLE.
- RD_ADDR (1 cycle): EN=0, OE=1, address stable. Load counter with RD_WAIT.
- RD_STROBE (RD_WAIT+1 cycles): EN=0, OE=0. On the clock edge that ends the last cycle (counter==0), ram1Data is captured into dataOut. Then go to DONE.
- WR_SETUP (1 cycle): EN=0, WE=1, bus driven with latched data. Load counter with WR_WIDTH-1.
- WR_PULSE (WR_WIDTH cycles): EN=0, WE=0, bus driven.
- WR_HOLD (1 cycle): EN=0, WE=1, bus still driven. Then go to DONE.
- DONE (1 cycle): EN=OE=WE=1, bus Z, memDone=1, memStall=0. Always returns to IDLE, never directly to a new access.
- memStall = (IDLE and (memRead or memWrite)) or (state not in {IDLE, DONE}). This is the only combinational output.
- ram1EN/OE/WE and bus-drive enable come straight from flops, with no decode glitches.
- dataOut changes only on a read capture. Writes leave it unchanged.
- Request inputs that change after acceptance have no effect until the next IDLE.

## Timing
- Reset (asynchronous, immediate): state=IDLE, counter=0, dataOut=0, memDone=0, ram1EN=ram1OE=ram1WE=1, ram1Data=Z, ram1Addr=0.
  - memStall follows its equation, so it is 0 unless a request is present.
- Reset mid-access aborts the access at once. A write cut off by reset leaves the SRAM content undefined.
- Read: request seen in IDLE at cycle 0; DONE at cycle 3+RD_WAIT; dataOut valid from that cycle.
- Write: request seen at cycle 0; DONE at cycle 3+WR_WIDTH.
- Address is stable at least 1 cycle before and after every OE/WE low window. Write data is stable 1 cycle before and 1 cycle after WE low.
- Bus turnaround: at least 2 cycles of Z (DONE, IDLE) after write data before OE falls for a following read.
- Back-to-back requests: the request held through DONE is consumed at the end of DONE by the pipeline. The next request is accepted in the following IDLE cycle.

## Test plan
- Reset: assert RST mid-RD_STROBE. Required: EN/OE/WE=1 and bus Z before the next edge; dataOut=0; IDLE after release.
- Read with RD_WAIT=1, address=0x0040, SRAM model returns 0xBEEF. Required: OE low exactly cycles 2–3; memDone at cycle 4; dataOut=0xBEEF; memStall high cycles 0–3.
- Write with WR_WIDTH=2, address=0x1234, dataIn=0x5A5A. Required: WE low cycles 2–3; bus=0x5A5A cycles 1–4; memDone at cycle 5; SRAM[0x1234]=0x5A5A; dataOut unchanged.
- Simultaneous memRead=memWrite=1, address 0x0010. Required: only a write sequence occurs; OE never low.
- Write 0xAAAA to 0x0002, then read 0x0002 back-to-back. Required: dataOut=0xAAAA; at least 2 Z cycles between bus drive and OE fall; never OE=0 while bus driven.
- Change address/dataIn mid-access. Required: ram1Addr and bus hold the latched values until DONE.
